// File: rtl/hls_channel_fifo.sv
// hls_channel_fifo
// Synchronous FIFO used as a kernel channel between generated HLS kernels.
// Pushes are accepted while not full and pops while not empty. A popped word
// is registered onto out_data and holds there until the next accepted pop.
//
// Ports:
//   clk          single clock, rising-edge active
//   rst          synchronous active-high reset
//   in_data      write data, sampled on an accepted push
//   write_valid  producer push strobe
//   read_valid   consumer pop strobe
//   out_data     registered data of the most recent pop
//   write_ready  high while count < DEPTH
//   read_ready   high while count > 0
//   count        current occupancy
module hls_channel_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       write_valid,
  input  logic                       read_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic                       write_ready,
  output logic                       read_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // Pointer advance with an explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] nxt;
    if (ptr == PTR_LAST) begin
      nxt = {PTR_W{1'b0}};
    end else begin
      nxt = ptr + PTR_W'(1);
    end
    return nxt;
  endfunction

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic [WIDTH-1:0] out_data_r;

  logic             full_s;
  logic             empty_s;
  logic             write_accept_s;
  logic             read_accept_s;

  // Accept decisions use only pre-edge registered state, so a push into an
  // empty FIFO is never bypassed to a same-cycle pop and a push into a full
  // FIFO is dropped even when a pop frees a slot in that same cycle.
  always_comb begin
    full_s         = (count_r == CNT_FULL);
    empty_s        = (count_r == {CNT_W{1'b0}});
    write_accept_s = write_valid && !full_s;
    read_accept_s  = read_valid && !empty_s;
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (write_accept_s && !rst) begin
      mem_r[tail_r] <= in_data;
    end
  end

  // Pointers, occupancy and the popped-data register; rst beats any strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r     <= {PTR_W{1'b0}};
      tail_r     <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      out_data_r <= {WIDTH{1'b0}};
    end else begin
      if (write_accept_s) begin
        tail_r <= next_ptr(tail_r);
      end
      if (read_accept_s) begin
        head_r     <= next_ptr(head_r);
        out_data_r <= mem_r[head_r];
      end
      case ({write_accept_s, read_accept_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Handshake outputs follow the registered occupancy only.
  always_comb begin
    write_ready = !full_s;
    read_ready  = !empty_s;
    count       = count_r;
    out_data    = out_data_r;
  end

endmodule
